// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and latches NUM_IRQ request lines, picks the lowest pending id and drives one CPU request.
// Optional macro IRQ_CTRL_NEST_EN allows preemption by strictly higher-priority requests.
module irq_ctrl #(
  parameter int              NUM_IRQ   = 8,
  parameter int              AW        = 16,
  parameter logic [AW-1:0]   VEC_RST   = 'h900,
  parameter int              VEC_SHIFT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  input  logic [2:0]         i_reg_addr,
  input  logic               i_reg_ren,
  input  logic               i_reg_wen,
  input  logic [15:0]        i_reg_wdata,
  output logic [15:0]        o_reg_rdata,
  output logic               o_irq_out,
  output logic [AW-1:0]      o_irq_vec,
  input  logic               i_irq_ack,
  input  logic               i_irq_eoi
);

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_EDGE    = 3'd2;
  localparam logic [2:0] A_CURRENT = 3'd3;
  localparam logic [2:0] A_VECBASE = 3'd4;

  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;
  logic [NUM_IRQ-1:0] r_sync_d;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_edge;
  logic [NUM_IRQ-1:0] r_insvc;
  logic [AW-1:0]      r_vec_base;
  logic [15:0]        r_rdata;
  logic               r_irq_out;

  logic [NUM_IRQ-1:0] w_req;
  logic               w_any;
  logic [3:0]         w_win;
  logic               w_insvc_any;
  logic [3:0]         w_cur_id;
  logic               w_ack;
  logic               w_eoi;
  logic [NUM_IRQ-1:0] w_win_oh;
  logic [NUM_IRQ-1:0] w_eoi_oh;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_w1c;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic [NUM_IRQ-1:0] w_insvc_nxt;
  logic               w_raise;
  logic [15:0]        w_rd_dat;

  assign w_req       = r_pending & r_mask;
  assign w_any       = |w_req;
  assign w_insvc_any = |r_insvc;

  // Scanning from the top down leaves the lowest set index as the result.
  always_comb begin
    w_win = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_win = 4'(i);
    end
  end

  always_comb begin
    w_cur_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_insvc[i]) w_cur_id = 4'(i);
    end
  end

  assign w_ack = r_irq_out && i_irq_ack && w_any;
  assign w_eoi = i_irq_eoi && w_insvc_any;

  always_comb begin
    w_win_oh = '0;
    w_eoi_oh = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_win_oh[i] = w_ack && (w_win == 4'(i));
      w_eoi_oh[i] = w_eoi && (w_cur_id == 4'(i));
    end
  end

  assign w_rise = r_sync2 & ~r_sync_d;
  assign w_w1c  = (i_reg_wen && (i_reg_addr == A_PENDING)) ? i_reg_wdata[NUM_IRQ-1:0] : '0;

  // Edge lines: a fresh rising edge beats any clear in the same cycle; level lines mirror the synced input.
  assign w_pending_nxt = (r_edge & ((r_pending & ~(w_w1c | w_win_oh)) | w_rise))
                       | (~r_edge & r_sync2);

  // EOI retires the current level before the ack pushes the new one.
  assign w_insvc_nxt = (r_insvc & ~w_eoi_oh) | w_win_oh;

`ifdef IRQ_CTRL_NEST_EN
  assign w_raise = w_any && (!w_insvc_any || (w_win < w_cur_id));
`else
  assign w_raise = w_any && !w_insvc_any;
`endif

  assign o_irq_vec = r_vec_base + (AW'(w_win) << VEC_SHIFT);

  always_comb begin
    w_rd_dat = '0;
    case (i_reg_addr)
      A_PENDING: w_rd_dat = 16'(r_pending);
      A_MASK:    w_rd_dat = 16'(r_mask);
      A_EDGE:    w_rd_dat = 16'(r_edge);
      A_CURRENT: w_rd_dat = w_insvc_any ? 16'(w_cur_id) : 16'hFFFF;
      A_VECBASE: w_rd_dat = 16'(r_vec_base);
      default:   w_rd_dat = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_sync_d   <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_edge     <= '0;
      r_insvc    <= '0;
      r_vec_base <= VEC_RST;
      r_rdata    <= '0;
      r_irq_out  <= 1'b0;
    end else begin
      r_sync1   <= i_irq_in;
      r_sync2   <= r_sync1;
      r_sync_d  <= r_sync2;
      r_pending <= w_pending_nxt;
      r_insvc   <= w_insvc_nxt;
      r_irq_out <= w_raise && !w_ack;
      if (i_reg_wen) begin
        case (i_reg_addr)
          A_MASK:    r_mask     <= i_reg_wdata[NUM_IRQ-1:0];
          A_EDGE:    r_edge     <= i_reg_wdata[NUM_IRQ-1:0];
          A_VECBASE: r_vec_base <= AW'(i_reg_wdata);
          default:   ;
        endcase
      end
      if (i_reg_ren) r_rdata <= w_rd_dat;
    end
  end

  assign o_reg_rdata = r_rdata;
  assign o_irq_out   = r_irq_out;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: register reads go through an expectation queue checked when read data appears;
// request/vector behaviour is checked inline in each scenario task.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_in = '0;
  logic [2:0]  reg_addr = '0;
  logic        reg_ren = 1'b0;
  logic        reg_wen = 1'b0;
  logic [15:0] reg_wdata = '0;
  logic [15:0] reg_rdata;
  logic        irq_out;
  logic [15:0] irq_vec;
  logic        irq_ack = 1'b0;
  logic        irq_eoi = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        ren_seen;
  logic [15:0] mon_exp;
  string       mon_name;

  irq_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_irq_in    (irq_in),
    .i_reg_addr  (reg_addr),
    .i_reg_ren   (reg_ren),
    .i_reg_wen   (reg_wen),
    .i_reg_wdata (reg_wdata),
    .o_reg_rdata (reg_rdata),
    .o_irq_out   (irq_out),
    .o_irq_vec   (irq_vec),
    .i_irq_ack   (irq_ack),
    .i_irq_eoi   (irq_eoi)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  // Read data is registered, so a strobe seen at one rising edge is compared at the following falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ren_seen <= 1'b0;
    else        ren_seen <= reg_ren;
  end

  always @(negedge clk) begin
    if (ren_seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h, required no read", reg_rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (reg_rdata !== mon_exp) begin
          errors++;
          $display("FAIL %s: got %h, required %h", mon_name, reg_rdata, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    reg_addr = a;
    reg_ren  = 1'b1;
    tick();
    reg_ren  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_wen   = 1'b1;
    tick();
    reg_wen   = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic eoi();
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out: got %b, required 0", irq_out); end
    checks++;
    if (reg_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0000", reg_rdata); end
    ticks(2);
    rst_n = 1'b1;
    tick();
    rd(3'd0, 16'h0000, "reset_pending");
    rd(3'd1, 16'h0000, "reset_mask");
    rd(3'd2, 16'h0000, "reset_edge");
    rd(3'd3, 16'hFFFF, "reset_current");
    rd(3'd4, 16'h0900, "reset_vec_base");
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL reset_irq_out_after: got %b, required 0", irq_out); end
  endtask

  task automatic test_registers();
    rd(3'd5, 16'h0000, "reg5_zero");
    wr(3'd6, 16'h1234);
    rd(3'd6, 16'h0000, "reg6_ignored");
    wr(3'd3, 16'h0005);
    rd(3'd3, 16'hFFFF, "current_readonly");
    wr(3'd4, 16'h0A00);
    rd(3'd4, 16'h0A00, "vec_base_rw");
    reg_addr = 3'd1;
    tick();
    checks++;
    if (reg_rdata !== 16'h0A00) begin errors++; $display("FAIL rdata_hold: got %h, required 0a00", reg_rdata); end
    wr(3'd4, 16'h0900);
    ack();
    rd(3'd3, 16'hFFFF, "ack_while_idle_ignored");
  endtask

  task automatic test_edge_irq();
    wr(3'd1, 16'h0004);
    wr(3'd2, 16'h0004);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    ticks(2);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_irq_early: got %b at edge 3, required 0", irq_out); end
    tick();
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL edge_irq_out: got %b at edge 4, required 1", irq_out); end
    checks++;
    if (irq_vec !== 16'h0920) begin errors++; $display("FAIL edge_irq_vec: got %h, required 0920", irq_vec); end
    rd(3'd0, 16'h0004, "edge_pending");
    ack();
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL edge_ack_drop: got %b, required 0", irq_out); end
    rd(3'd3, 16'h0002, "edge_current");
    rd(3'd0, 16'h0000, "edge_pending_cleared_by_ack");
    eoi();
    rd(3'd3, 16'hFFFF, "edge_current_after_eoi");
  endtask

  task automatic test_priority();
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h00FF);
    irq_in[5] = 1'b1;
    irq_in[1] = 1'b1;
    ticks(4);
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL prio_irq_out: got %b, required 1", irq_out); end
    checks++;
    if (irq_vec !== 16'h0910) begin errors++; $display("FAIL prio_vec_first: got %h, required 0910", irq_vec); end
    ack();
    rd(3'd3, 16'h0001, "prio_current_first");
    eoi();
    tick();
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL prio_second_irq: got %b, required 1", irq_out); end
    checks++;
    if (irq_vec !== 16'h0950) begin errors++; $display("FAIL prio_vec_second: got %h, required 0950", irq_vec); end
    ack();
    rd(3'd3, 16'h0005, "prio_current_second");
    eoi();
    irq_in = '0;
    ticks(3);
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL prio_idle: got %b, required 0", irq_out); end
    rd(3'd0, 16'h0000, "prio_pending_empty");
  endtask

  task automatic test_level();
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0000);
    irq_in[3] = 1'b1;
    ticks(3);
    rd(3'd0, 16'h0008, "level_pending");
    wr(3'd0, 16'h0008);
    rd(3'd0, 16'h0008, "level_w1c_no_effect");
    irq_in[3] = 1'b0;
    ticks(2);
    rd(3'd0, 16'h0008, "level_drop_edge3");
    rd(3'd0, 16'h0000, "level_drop_cleared");
    wr(3'd2, 16'h0004);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    ticks(3);
    rd(3'd0, 16'h0004, "edge_latched_mask_off");
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0000, "edge_w1c_clears");
  endtask

  task automatic test_nesting();
    wr(3'd1, 16'h00FF);
    wr(3'd2, 16'h00FF);
    irq_in[4] = 1'b1;
    ticks(4);
    checks++;
    if (irq_vec !== 16'h0940 || irq_out !== 1'b1) begin
      errors++; $display("FAIL nest_line4: got out=%b vec=%h, required out=1 vec=0940", irq_out, irq_vec);
    end
    ack();
    rd(3'd3, 16'h0004, "nest_current_4");
    irq_in[0] = 1'b1;
    ticks(5);
`ifdef IRQ_CTRL_NEST_EN
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL nest_preempt: got %b, required 1", irq_out); end
    checks++;
    if (irq_vec !== 16'h0900) begin errors++; $display("FAIL nest_preempt_vec: got %h, required 0900", irq_vec); end
    ack();
    rd(3'd3, 16'h0000, "nest_current_0");
    eoi();
    rd(3'd3, 16'h0004, "nest_current_back_4");
    eoi();
    rd(3'd3, 16'hFFFF, "nest_current_none");
`else
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL single_blocked: got %b, required 0", irq_out); end
    ack();
    rd(3'd3, 16'h0004, "single_ack_ignored");
    rd(3'd0, 16'h0001, "single_pending_0");
    eoi();
    tick();
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL single_after_eoi: got %b, required 1", irq_out); end
    checks++;
    if (irq_vec !== 16'h0900) begin errors++; $display("FAIL single_vec: got %h, required 0900", irq_vec); end
    ack();
    rd(3'd3, 16'h0000, "single_current_0");
    eoi();
    rd(3'd3, 16'hFFFF, "single_current_none");
`endif
    irq_in = '0;
    ticks(3);
  endtask

  task automatic test_back_to_back();
    wr(3'd1, 16'h0000);
    wr(3'd2, 16'h0004);
    irq_in[2] = 1'b1;
    tick();
    irq_in[2] = 1'b0;
    ticks(4);
    rd(3'd0, 16'h0004, "simul_preset");
    irq_in[2] = 1'b1;
    ticks(2);
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0004, "simul_set_wins");
    wr(3'd0, 16'h0004);
    rd(3'd0, 16'h0000, "simul_w1c_after");
    irq_in[2] = 1'b0;
    ticks(3);
    wr(3'd1, 16'h0004);
    irq_in[2] = 1'b1;
    ticks(4);
    checks++;
    if (irq_out !== 1'b1) begin errors++; $display("FAIL rst_pre_irq: got %b, required 1", irq_out); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_async_irq: got %b, required 0", irq_out); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_no_glitch: got %b at cycle %0d, required 0", irq_out, k); end
    end
    rd(3'd1, 16'h0000, "rst_mask_cleared");
    rd(3'd0, 16'h0004, "rst_level_mode_pending");
    rd(3'd3, 16'hFFFF, "rst_current_none");
    irq_in = '0;
  endtask

  initial begin
    test_reset();
    test_registers();
    test_edge_irq();
    test_priority();
    test_level();
    test_nesting();
    test_back_to_back();
    ticks(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding reads, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
